// File: rtl/pipeline_stall_controller_pkg.sv
// Shared state encodings and pipeline-control bundle for the RV32IM stall controller.
package pipeline_ctrl_pkg;

  localparam int STALL_STATE_W = 2;

  localparam logic [STALL_STATE_W-1:0] RUN      = 2'd0;
  localparam logic [STALL_STATE_W-1:0] LOAD_BUB = 2'd1;
  localparam logic [STALL_STATE_W-1:0] MULDIV   = 2'd2;
  localparam logic [STALL_STATE_W-1:0] MEMWAIT  = 2'd3;

  typedef struct packed {
    logic pc_we;
    logic if_id_we;
    logic if_id_flush;
    logic id_ex_bubble;
    logic ex_mem_we;
  } pipe_ctrl_t;

  // States in which EX is held by a multi-cycle condition and the watchdog runs.
  function automatic logic is_long_stall(input logic [STALL_STATE_W-1:0] s);
    return (s == MULDIV) || (s == MEMWAIT);
  endfunction

endpackage

// File: rtl/pipeline_stall_controller_if.sv
// Hazard-request inputs and pipeline-register control outputs of the stall controller.
interface pipeline_stall_controller_if;

  logic bubble_enable;
  logic fwd_wb_rs1_in;
  logic fwd_wb_rs2_in;
  logic branch_taken;
  logic muldiv_start;
  logic muldiv_done;
  logic dmem_busy;

  logic pc_write_en;
  logic if_id_write_en;
  logic if_id_flush;
  logic id_ex_bubble;
  logic ex_mem_write_en;
  logic fwd_wb_rs1;
  logic fwd_wb_rs2;

  modport master (
    output bubble_enable, fwd_wb_rs1_in, fwd_wb_rs2_in, branch_taken,
           muldiv_start, muldiv_done, dmem_busy,
    input  pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble,
           ex_mem_write_en, fwd_wb_rs1, fwd_wb_rs2
  );

  modport slave (
    input  bubble_enable, fwd_wb_rs1_in, fwd_wb_rs2_in, branch_taken,
           muldiv_start, muldiv_done, dmem_busy,
    output pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble,
           ex_mem_write_en, fwd_wb_rs1, fwd_wb_rs2
  );

endinterface

// File: rtl/pipeline_stall_controller_sat_counter.sv
// Up-counter that sticks at all-ones; clear takes priority over enable.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         clear,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !(&count)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Stall/flush controller: turns hazard and multi-cycle wait requests into
// pipeline-register enables, IF/ID flush, ID/EX bubble and aligned WB forwards.
module pipeline_stall_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int STALL_CNT_W     = 16,
  parameter int WATCHDOG_CYCLES = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  pipeline_stall_controller_if.slave hz,
  output logic [STALL_STATE_W-1:0] stall_state,
  output logic [STALL_CNT_W-1:0]   stall_cycle_count,
  output logic                     watchdog_err
);

  localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);

  logic [STALL_STATE_W-1:0] state;
  logic [STALL_STATE_W-1:0] state_next;
  logic                     bubble_accept;
  logic                     branch_squash;
  logic                     fwd_release;
  logic                     fwd_pend;
  logic                     cap_rs1;
  logic                     cap_rs2;
  logic                     fwd_rs1_q;
  logic                     fwd_rs2_q;
  logic                     wd_enable;
  logic                     wd_clear;
  logic [WD_W-1:0]          wd_count;
  pipe_ctrl_t               ctrl;

  // Priority dmem_busy > muldiv_start > branch_taken > bubble_enable.
  always_comb begin
    state_next    = state;
    bubble_accept = 1'b0;
    branch_squash = 1'b0;
    case (state)
      RUN: begin
        if (hz.dmem_busy) begin
          state_next = MEMWAIT;
        end else if (hz.muldiv_start) begin
          state_next = MULDIV;
        end else if (hz.branch_taken) begin
          branch_squash = 1'b1;
        end else if (hz.bubble_enable) begin
          state_next    = LOAD_BUB;
          bubble_accept = 1'b1;
        end
      end
      LOAD_BUB: state_next = hz.dmem_busy ? MEMWAIT : RUN;
      MULDIV: begin
        if (hz.muldiv_done) begin
          state_next = hz.dmem_busy ? MEMWAIT : RUN;
        end
      end
      default: begin
        if (!hz.dmem_busy) begin
          state_next = RUN;
        end
      end
    endcase
  end

  // Redirect is only honoured in RUN; while EX is held it replays later.
  always_comb begin
    ctrl = '{pc_we: 1'b1, if_id_we: 1'b1, if_id_flush: 1'b0,
             id_ex_bubble: 1'b0, ex_mem_we: 1'b1};
    case (state)
      RUN: begin
        if (hz.branch_taken && reset) begin
          ctrl.if_id_flush  = 1'b1;
          ctrl.id_ex_bubble = 1'b1;
        end
      end
      LOAD_BUB: begin
        ctrl.pc_we        = 1'b0;
        ctrl.if_id_we     = 1'b0;
        ctrl.id_ex_bubble = 1'b1;
      end
      MULDIV: begin
        ctrl.pc_we     = 1'b0;
        ctrl.if_id_we  = 1'b0;
        ctrl.ex_mem_we = 1'b0;
      end
      default: begin
        ctrl.pc_we     = 1'b0;
        ctrl.if_id_we  = 1'b0;
        ctrl.ex_mem_we = 1'b0;
      end
    endcase
  end

  // Captured forwards survive a memory wait and surface for the first RUN cycle only.
  assign fwd_release = (state != RUN) && (state_next == RUN) && fwd_pend;
  assign wd_enable   = is_long_stall(state);
  assign wd_clear    = is_long_stall(state_next) && (state_next != state);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= RUN;
      fwd_pend     <= 1'b0;
      cap_rs1      <= 1'b0;
      cap_rs2      <= 1'b0;
      fwd_rs1_q    <= 1'b0;
      fwd_rs2_q    <= 1'b0;
      watchdog_err <= 1'b0;
    end else begin
      state <= state_next;
      if (bubble_accept) begin
        cap_rs1  <= hz.fwd_wb_rs1_in;
        cap_rs2  <= hz.fwd_wb_rs2_in;
        fwd_pend <= 1'b1;
      end else if (branch_squash) begin
        cap_rs1  <= 1'b0;
        cap_rs2  <= 1'b0;
        fwd_pend <= 1'b0;
      end else if (fwd_release) begin
        fwd_pend <= 1'b0;
      end
      fwd_rs1_q <= fwd_release & cap_rs1;
      fwd_rs2_q <= fwd_release & cap_rs2;
      if (wd_enable && (wd_count == WD_W'(WATCHDOG_CYCLES - 1))) begin
        watchdog_err <= 1'b1;
      end
    end
  end

  sat_counter #(.W(STALL_CNT_W)) u_stall_cnt (
    .clk    (clk),
    .reset  (reset),
    .enable (~ctrl.pc_we),
    .clear  (1'b0),
    .count  (stall_cycle_count)
  );

  sat_counter #(.W(WD_W)) u_wd_cnt (
    .clk    (clk),
    .reset  (reset),
    .enable (wd_enable),
    .clear  (wd_clear),
    .count  (wd_count)
  );

  assign hz.pc_write_en     = ctrl.pc_we;
  assign hz.if_id_write_en  = ctrl.if_id_we;
  assign hz.if_id_flush     = ctrl.if_id_flush;
  assign hz.id_ex_bubble    = ctrl.id_ex_bubble;
  assign hz.ex_mem_write_en = ctrl.ex_mem_we;
  assign hz.fwd_wb_rs1      = fwd_rs1_q;
  assign hz.fwd_wb_rs2      = fwd_rs2_q;
  assign stall_state        = state;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller with a per-cycle reference model
// and hand-computed checkpoints.
module tb_pipeline_stall_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  stall_state;
  logic [15:0] stall_cycle_count;
  logic        watchdog_err;
  int          checks = 0;
  int          failures = 0;

  pipeline_stall_controller_if bus ();

  pipeline_stall_controller #(
    .STALL_CNT_W     (16),
    .WATCHDOG_CYCLES (64)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .hz                (bus),
    .stall_state       (stall_state),
    .stall_cycle_count (stall_cycle_count),
    .watchdog_err      (watchdog_err)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  // Reference model: what the pipe is doing, expressed as a mode plus bookkeeping.
  typedef enum int {M_RUN = 0, M_LOAD_BUB = 1, M_MULDIV = 2, M_MEMWAIT = 3} mode_t;
  mode_t m_mode;
  bit    m_pend, m_cap1, m_cap2, m_fwd1, m_fwd2, m_wd;
  int    m_stalls, m_streak;

  task automatic model_reset();
    m_mode = M_RUN;
    m_pend = 0; m_cap1 = 0; m_cap2 = 0; m_fwd1 = 0; m_fwd2 = 0; m_wd = 0;
    m_stalls = 0; m_streak = 0;
  endtask

  task automatic model_compare();
    bit frontend_frozen, ex_held, squash;
    frontend_frozen = (m_mode != M_RUN);
    ex_held = (m_mode == M_MULDIV) || (m_mode == M_MEMWAIT);
    squash = reset && (m_mode == M_RUN) && bus.branch_taken;
    check_output("pc_write_en",     int'(bus.pc_write_en),     int'(!frontend_frozen));
    check_output("if_id_write_en",  int'(bus.if_id_write_en),  int'(!frontend_frozen));
    check_output("ex_mem_write_en", int'(bus.ex_mem_write_en), int'(!ex_held));
    check_output("if_id_flush",     int'(bus.if_id_flush),     int'(squash));
    check_output("id_ex_bubble",    int'(bus.id_ex_bubble),    int'(squash || m_mode == M_LOAD_BUB));
    check_output("fwd_wb_rs1",      int'(bus.fwd_wb_rs1),      int'(m_fwd1));
    check_output("fwd_wb_rs2",      int'(bus.fwd_wb_rs2),      int'(m_fwd2));
    check_output("stall_state",     int'(stall_state),         int'(m_mode));
    check_output("stall_cycle_count", int'(stall_cycle_count), m_stalls);
    check_output("watchdog_err",    int'(watchdog_err),        int'(m_wd));
  endtask

  task automatic model_step();
    mode_t nxt;
    nxt = m_mode;
    if (m_mode != M_RUN && m_stalls < 65535) m_stalls++;
    if (m_mode == M_MULDIV || m_mode == M_MEMWAIT) begin
      m_streak++;
      if (m_streak >= 64) m_wd = 1;
    end
    case (m_mode)
      M_RUN: begin
        if (bus.dmem_busy) nxt = M_MEMWAIT;
        else if (bus.muldiv_start) nxt = M_MULDIV;
        else if (bus.branch_taken) m_pend = 0;
        else if (bus.bubble_enable) begin
          nxt = M_LOAD_BUB;
          m_pend = 1;
          m_cap1 = bus.fwd_wb_rs1_in;
          m_cap2 = bus.fwd_wb_rs2_in;
        end
      end
      M_LOAD_BUB: nxt = bus.dmem_busy ? M_MEMWAIT : M_RUN;
      M_MULDIV:   if (bus.muldiv_done) nxt = bus.dmem_busy ? M_MEMWAIT : M_RUN;
      default:    if (!bus.dmem_busy) nxt = M_RUN;
    endcase
    m_fwd1 = 0;
    m_fwd2 = 0;
    if (nxt == M_RUN && m_mode != M_RUN && m_pend) begin
      m_fwd1 = m_cap1;
      m_fwd2 = m_cap2;
      m_pend = 0;
    end
    if (nxt != m_mode) m_streak = 0;
    m_mode = nxt;
  endtask

  always @(negedge clk) begin
    if (!reset) model_reset();
    model_compare();
    if (reset) model_step();
  end

  task automatic apply_stimulus(input logic be, input logic r1, input logic r2, input logic br,
                                input logic ms, input logic md, input logic db);
    bus.bubble_enable = be;
    bus.fwd_wb_rs1_in = r1;
    bus.fwd_wb_rs2_in = r2;
    bus.branch_taken  = br;
    bus.muldiv_start  = ms;
    bus.muldiv_done   = md;
    bus.dmem_busy     = db;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    model_reset();
    apply_stimulus(0, 0, 0, 0, 0, 0, 0);
    check_output("reset pc_write_en", int'(bus.pc_write_en), 1);
    check_output("reset stall_state", int'(stall_state), 0);
    check_output("reset count", int'(stall_cycle_count), 0);
    tick();
    tick();
    reset = 1'b1;

    // Load-use bubble with rs1 forward.
    apply_stimulus(1, 1, 0, 0, 0, 0, 0); tick();
    apply_stimulus(0, 0, 0, 0, 0, 0, 0);
    check_output("t1 pc_we in bubble", int'(bus.pc_write_en), 0);
    check_output("t1 id_ex_bubble", int'(bus.id_ex_bubble), 1);
    tick();
    apply_stimulus(0, 0, 0, 0, 0, 0, 0);
    check_output("t1 fwd_rs1", int'(bus.fwd_wb_rs1), 1);
    check_output("t1 fwd_rs2", int'(bus.fwd_wb_rs2), 0);
    tick();
    apply_stimulus(0, 0, 0, 0, 0, 0, 0);
    check_output("t1 fwd_rs1 cleared", int'(bus.fwd_wb_rs1), 0);
    check_output("t1 count", int'(stall_cycle_count), 1);
    tick();

    // Branch beats a coincident bubble request.
    apply_stimulus(1, 1, 1, 1, 0, 0, 0);
    check_output("t2 flush", int'(bus.if_id_flush), 1);
    check_output("t2 bubble", int'(bus.id_ex_bubble), 1);
    check_output("t2 pc_we", int'(bus.pc_write_en), 1);
    tick();
    apply_stimulus(0, 0, 0, 0, 0, 0, 0);
    check_output("t2 state", int'(stall_state), 0);
    tick();
    apply_stimulus(0, 0, 0, 0, 0, 0, 0);
    check_output("t2 fwd_rs1", int'(bus.fwd_wb_rs1), 0);
    tick();

    // 33-cycle MUL/DIV with a redirect arriving while EX is held.
    apply_stimulus(0, 0, 0, 0, 1, 0, 0); tick();
    for (int i = 0; i < 32; i++) begin
      apply_stimulus(0, 0, 0, (i == 5), 0, 0, 0);
      if (i == 5) check_output("t3 flush ignored", int'(bus.if_id_flush), 0);
      tick();
    end
    apply_stimulus(0, 0, 0, 0, 0, 1, 0);
    check_output("t3 ex_mem_we on done", int'(bus.ex_mem_write_en), 0);
    tick();
    apply_stimulus(0, 0, 0, 0, 0, 0, 0);
    check_output("t3 state", int'(stall_state), 0);
    check_output("t3 count", int'(stall_cycle_count), 34);
    check_output("t3 watchdog", int'(watchdog_err), 0);
    tick();

    // Priority: memory wait beats MUL/DIV start and MUL/DIV completion.
    apply_stimulus(0, 0, 0, 0, 1, 0, 1); tick();
    apply_stimulus(0, 0, 0, 0, 0, 0, 0);
    check_output("prio state", int'(stall_state), 3);
    tick();
    apply_stimulus(0, 0, 0, 0, 1, 0, 0); tick();
    apply_stimulus(0, 0, 0, 0, 0, 1, 1); tick();
    apply_stimulus(0, 0, 0, 0, 0, 0, 1);
    check_output("done+busy state", int'(stall_state), 3);
    tick();
    apply_stimulus(0, 0, 0, 0, 0, 0, 0); tick();
    apply_stimulus(0, 1, 1, 0, 0, 0, 0); tick();

    // Load bubble interrupted by memory wait, rs2 forward pending across it.
    apply_stimulus(1, 0, 1, 0, 0, 0, 0); tick();
    apply_stimulus(0, 0, 0, 0, 0, 0, 1); tick();
    apply_stimulus(0, 0, 0, 0, 0, 0, 0); tick();
    apply_stimulus(0, 0, 0, 0, 0, 0, 0); tick();
    apply_stimulus(0, 0, 0, 0, 0, 0, 0);
    check_output("pre-t4 count", int'(stall_cycle_count), 40);
    tick();

    // Long memory wait trips the watchdog.
    for (int i = 0; i < 70; i++) begin
      apply_stimulus(0, 0, 0, 0, 0, 0, 1);
      if (i == 64) check_output("t4 watchdog before", int'(watchdog_err), 0);
      if (i == 65) check_output("t4 watchdog after", int'(watchdog_err), 1);
      if (i == 30) check_output("t4 ex_mem_we", int'(bus.ex_mem_write_en), 0);
      tick();
    end
    apply_stimulus(0, 0, 0, 0, 0, 0, 0); tick();
    apply_stimulus(0, 0, 0, 0, 0, 0, 0);
    check_output("t4 state", int'(stall_state), 0);
    check_output("t4 watchdog sticky", int'(watchdog_err), 1);
    check_output("t4 count", int'(stall_cycle_count), 110);
    tick();

    // Asynchronous reset in the middle of a MUL/DIV stall.
    apply_stimulus(0, 0, 0, 0, 1, 0, 0); tick();
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(0, 0, 0, 0, 0, 0, 0); tick();
    end
    apply_stimulus(0, 0, 0, 0, 0, 0, 0);
    check_output("t5 before reset state", int'(stall_state), 2);
    reset = 1'b0;
    #1;
    check_output("t5 async pc_we", int'(bus.pc_write_en), 1);
    check_output("t5 async ex_mem_we", int'(bus.ex_mem_write_en), 1);
    check_output("t5 async state", int'(stall_state), 0);
    check_output("t5 async count", int'(stall_cycle_count), 0);
    check_output("t5 async watchdog", int'(watchdog_err), 0);
    tick();
    apply_stimulus(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    tick();
    apply_stimulus(0, 0, 0, 0, 0, 0, 0);
    check_output("t5 after state", int'(stall_state), 0);
    check_output("t5 after count", int'(stall_cycle_count), 0);
    tick();
    apply_stimulus(1, 1, 1, 0, 0, 0, 0); tick();
    apply_stimulus(0, 0, 0, 0, 0, 0, 0);
    check_output("t5 bubble state", int'(stall_state), 1);
    tick();
    apply_stimulus(0, 0, 0, 0, 0, 0, 0); tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
